// File: rtl/cordic_sincos_ctrl_if.sv
// Valid/ready bus between an angle producer and the CORDIC sine/cosine engine.
// The master drives the angle and consumes the result; the slave is the engine.
interface cordic_sincos_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] angle;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sine;
  logic [WIDTH-1:0] cosine;
  logic             busy;

  modport master (
    output in_valid, angle, out_ready,
    input  in_ready, out_valid, sine, cosine, busy
  );

  modport slave (
    input  in_valid, angle, out_ready,
    output in_ready, out_valid, sine, cosine, busy
  );
endinterface

// File: rtl/cordic_sincos_ctrl.sv
// Iterative CORDIC sine/cosine engine: folds a Q5.27 angle into [0, pi/2], runs
// ITERATIONS micro-rotations on one shared shift/add datapath, then restores quadrant signs.
module cordic_sincos_ctrl #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 24
) (
  input logic                 clk,
  input logic                 rst,
  cordic_sincos_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROTATE, FIX, DONE} state_t;

  localparam logic signed [WIDTH-1:0] HALF_PI       = 32'sh0C90FDAA;
  localparam logic signed [WIDTH-1:0] PI            = 32'sh1921FB54;
  localparam logic signed [WIDTH-1:0] THREE_HALF_PI = 32'sh25B2F8FE;
  localparam logic signed [WIDTH-1:0] TWO_PI        = 32'sh3243F6A9;
  localparam logic signed [WIDTH-1:0] K_GAIN        = 32'sh04DBA76D;
  localparam logic [4:0]              LAST_ITER     = 5'(ITERATIONS - 1);

  // round(atan(2^-i) * 2^27)
  function automatic logic signed [WIDTH-1:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    atan_lut = 32'sh06487ED5;
      5'd1:    atan_lut = 32'sh03B58CE1;
      5'd2:    atan_lut = 32'sh01F5B760;
      5'd3:    atan_lut = 32'sh00FEADD5;
      5'd4:    atan_lut = 32'sh007FD56F;
      5'd5:    atan_lut = 32'sh003FFAAB;
      5'd6:    atan_lut = 32'sh001FFF55;
      5'd7:    atan_lut = 32'sh000FFFEB;
      5'd8:    atan_lut = 32'sh0007FFFD;
      5'd9:    atan_lut = 32'sh00040000;
      5'd10:   atan_lut = 32'sh00020000;
      5'd11:   atan_lut = 32'sh00010000;
      5'd12:   atan_lut = 32'sh00008000;
      5'd13:   atan_lut = 32'sh00004000;
      5'd14:   atan_lut = 32'sh00002000;
      5'd15:   atan_lut = 32'sh00001000;
      5'd16:   atan_lut = 32'sh00000800;
      5'd17:   atan_lut = 32'sh00000400;
      5'd18:   atan_lut = 32'sh00000200;
      5'd19:   atan_lut = 32'sh00000100;
      5'd20:   atan_lut = 32'sh00000080;
      5'd21:   atan_lut = 32'sh00000040;
      5'd22:   atan_lut = 32'sh00000020;
      5'd23:   atan_lut = 32'sh00000010;
      5'd24:   atan_lut = 32'sh00000008;
      5'd25:   atan_lut = 32'sh00000004;
      5'd26:   atan_lut = 32'sh00000002;
      default: atan_lut = '0;
    endcase
  endfunction

  state_t                  state, state_next;
  logic signed [WIDTH-1:0] x, y, z;
  logic signed [WIDTH-1:0] sine_q, cosine_q;
  logic [4:0]              iter;
  logic                    s_neg, c_neg, out_valid_q;

  logic signed [WIDTH-1:0] ang_in, ang_wrapped, z0;
  logic                    s0, c0, accept, d_pos;
  logic signed [WIDTH-1:0] x_shift, y_shift, atan_i;

  assign ang_in  = $signed(bus.angle);
  assign accept  = (state == IDLE) && bus.in_valid;
  assign d_pos   = ~z[WIDTH-1];
  assign x_shift = x >>> iter;
  assign y_shift = y >>> iter;
  assign atan_i  = atan_lut(iter);

  // Wrap into [0, 2pi), then reflect into the first quadrant and remember the signs
  always_comb begin
    ang_wrapped = ang_in;
    z0          = '0;
    s0          = 1'b0;
    c0          = 1'b0;
    if (ang_in < 0)
      ang_wrapped = ang_in + TWO_PI;
    else if (ang_in >= TWO_PI)
      ang_wrapped = ang_in - TWO_PI;

    if (ang_wrapped <= HALF_PI) begin
      z0 = ang_wrapped;
    end else if (ang_wrapped <= PI) begin
      z0 = PI - ang_wrapped;
      c0 = 1'b1;
    end else if (ang_wrapped <= THREE_HALF_PI) begin
      z0 = ang_wrapped - PI;
      s0 = 1'b1;
      c0 = 1'b1;
    end else begin
      z0 = TWO_PI - ang_wrapped;
      s0 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ROTATE;
      ROTATE:  if (iter == LAST_ITER) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shared rotation datapath; every update reads the pre-edge x, y and z
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      z           <= '0;
      iter        <= '0;
      s_neg       <= 1'b0;
      c_neg       <= 1'b0;
      sine_q      <= '0;
      cosine_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x     <= K_GAIN;
            y     <= '0;
            z     <= z0;
            s_neg <= s0;
            c_neg <= c0;
            iter  <= '0;
          end
        end
        ROTATE: begin
          if (d_pos) begin
            x <= x - y_shift;
            y <= y + x_shift;
            z <= z - atan_i;
          end else begin
            x <= x + y_shift;
            y <= y - x_shift;
            z <= z + atan_i;
          end
          iter <= iter + 5'd1;
        end
        FIX: begin
          sine_q      <= s_neg ? -y : y;
          cosine_q    <= c_neg ? -x : x;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sine      = sine_q;
  assign bus.cosine    = cosine_q;
endmodule
